// File: rtl/conv_max_pool_pkg.sv
// conv_max_pool_pkg: shared constants, row-state encoding and helpers for the pooling stage.
// Contents: CH_NUM / DATA_WIDTH / LEN_WIDTH / MAX_LEN (also used by the conv unit),
// derived buffer geometry, row_state_t, a signed lane max and a line-length clamp.
package conv_max_pool_pkg;
    localparam int CH_NUM     = 18;
    localparam int DATA_WIDTH = 8;
    localparam int LEN_WIDTH  = 9;
    localparam int MAX_LEN    = 320;
    localparam int BUF_DEPTH  = MAX_LEN / 2;
    localparam int ADDR_WIDTH = $clog2(BUF_DEPTH);
    localparam int PIX_WIDTH  = CH_NUM * DATA_WIDTH;

    typedef enum logic {EVEN_ROW = 1'b0, ODD_ROW = 1'b1} row_state_t;

    function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        return (len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : len;
    endfunction
endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: simple dual-port line buffer holding one horizontal max per column pair.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_re/i_raddr read port;
// o_rdata registered read data, held while i_re is low. Contents are never reset.
module pool_line_buf
    import conv_max_pool_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [PIX_WIDTH-1:0]  i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [PIX_WIDTH-1:0]  o_rdata
);
    logic [PIX_WIDTH-1:0] r_mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/conv_max_pool.sv
// conv_max_pool: 2x2 stride-2 signed max pooling over an 18-lane pixel stream, with bypass.
// Ports: clk, rst (sync, active-high); pool_rst frame restart, samples pool_en/line_len;
// pool_data_in/pool_valid_in raster-order input beats; pool_data_out/pool_valid_out pooled
// (or bypassed) pixel one cycle later; pool_row_done marks the last pooled pixel of a row.
module conv_max_pool
    import conv_max_pool_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pool_rst,
    input  logic                 pool_en,
    input  logic [LEN_WIDTH-1:0] line_len,
    input  logic [PIX_WIDTH-1:0] pool_data_in,
    input  logic                 pool_valid_in,
    output logic [PIX_WIDTH-1:0] pool_data_out,
    output logic                 pool_valid_out,
    output logic                 pool_row_done
);
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] TWO = LEN_WIDTH'(2);

    row_state_t           r_state, w_next_state;
    logic [LEN_WIDTH-1:0] r_col_cnt, w_next_col, r_len;
    logic                 r_pool_en;
    logic [PIX_WIDTH-1:0] r_prev, w_hmax, w_pool, w_rdata;
    logic                 w_beat, w_last, w_odd_col, w_skip, w_row_end;
    logic                 w_latch, w_rd, w_wr, w_fire;

    // Beats arriving with rst/pool_rst are dropped, so they never touch the buffer.
    assign w_beat    = pool_valid_in && r_pool_en && !rst && !pool_rst;
    // Lines shorter than 2 wrap on every beat.
    assign w_last    = (r_len < TWO) || (r_col_cnt == r_len - ONE);
    assign w_odd_col = r_col_cnt[0];
    // Trailing unpaired column of an odd-length line.
    assign w_skip    = w_last && r_len[0];
    assign w_row_end = r_col_cnt == ({r_len[LEN_WIDTH-1:1], 1'b0} - ONE);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
        assign w_hmax[i*DATA_WIDTH +: DATA_WIDTH] = smax(r_prev[i*DATA_WIDTH +: DATA_WIDTH], pool_data_in[i*DATA_WIDTH +: DATA_WIDTH]);
        assign w_pool[i*DATA_WIDTH +: DATA_WIDTH] = smax(w_rdata[i*DATA_WIDTH +: DATA_WIDTH], w_hmax[i*DATA_WIDTH +: DATA_WIDTH]);
    end

    pool_line_buf u_buf (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_col_cnt[LEN_WIDTH-1:1]),
        .i_wdata (w_hmax),
        .i_re    (w_rd),
        .i_raddr (r_col_cnt[LEN_WIDTH-1:1]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst || pool_rst) begin
            r_state   <= EVEN_ROW;
            r_col_cnt <= '0;
            r_len     <= clamp_len(line_len);
            r_pool_en <= rst ? 1'b1 : pool_en;
        end else begin
            r_state   <= w_next_state;
            r_col_cnt <= w_next_col;
        end
    end

    always_comb begin
        w_next_col   = w_beat ? (w_last ? '0 : r_col_cnt + ONE) : r_col_cnt;
        w_next_state = (w_beat && w_last) ? ((r_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW) : r_state;
    end

    // Even column latches the left pixel (and prefetches the upper-row max on odd rows);
    // odd column either stores the horizontal max or completes a window.
    always_comb begin
        w_latch = w_beat && !w_odd_col && !w_skip;
        w_rd    = w_latch && (r_state == ODD_ROW);
        w_wr    = w_beat && w_odd_col && (r_state == EVEN_ROW);
        w_fire  = w_beat && w_odd_col && (r_state == ODD_ROW);
    end

    always_ff @(posedge clk) begin
        if (w_latch) r_prev <= pool_data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pool_data_out  <= '0;
            pool_valid_out <= 1'b0;
            pool_row_done  <= 1'b0;
        end else if (pool_rst) begin
            pool_valid_out <= 1'b0;
            pool_row_done  <= 1'b0;
        end else begin
            pool_valid_out <= r_pool_en ? w_fire : pool_valid_in;
            pool_row_done  <= w_fire && w_row_end;
            if (!r_pool_en || w_fire) pool_data_out <= r_pool_en ? w_pool : pool_data_in;
        end
    end
endmodule

// File: tb/tb_conv_max_pool.sv
// tb_conv_max_pool: table-driven bench for conv_max_pool; one record per clock cycle.
module tb_conv_max_pool;
    import conv_max_pool_pkg::*;

    typedef struct {
        logic                 rs, prst, v, en;
        logic [LEN_WIDTH-1:0] len;
        logic [PIX_WIDTH-1:0] din;
        logic                 ev, edone, chk;
        logic [PIX_WIDTH-1:0] ed;
    } vec_t;

    vec_t q[$];

    logic                 clk = 1'b0;
    logic                 rst, pool_rst, pool_en, pool_valid_in;
    logic [LEN_WIDTH-1:0] line_len;
    logic [PIX_WIDTH-1:0] pool_data_in, pool_data_out;
    logic                 pool_valid_out, pool_row_done;
    logic [LEN_WIDTH-1:0] cur_len;
    logic                 cur_en;
    int                   n_chk = 0;
    int                   n_fail = 0;

    always #5 clk = ~clk;

    conv_max_pool dut (
        .clk            (clk),
        .rst            (rst),
        .pool_rst       (pool_rst),
        .pool_en        (pool_en),
        .line_len       (line_len),
        .pool_data_in   (pool_data_in),
        .pool_valid_in  (pool_valid_in),
        .pool_data_out  (pool_data_out),
        .pool_valid_out (pool_valid_out),
        .pool_row_done  (pool_row_done)
    );

    // Even lanes rise with p, odd lanes fall with p: window max maps to lane max / lane min.
    function automatic logic [PIX_WIDTH-1:0] mk(input int p);
        logic [PIX_WIDTH-1:0] r;
        for (int k = 0; k < CH_NUM; k++) r[k*DATA_WIDTH +: DATA_WIDTH] = (k % 2 == 0) ? 8'(p + 3*k) : 8'(-p - k);
        return r;
    endfunction

    function automatic logic [PIX_WIDTH-1:0] mk_exp(input int mx, input int mn);
        logic [PIX_WIDTH-1:0] r;
        for (int k = 0; k < CH_NUM; k++) r[k*DATA_WIDTH +: DATA_WIDTH] = (k % 2 == 0) ? 8'(mx + 3*k) : 8'(-mn - k);
        return r;
    endfunction

    function automatic logic [PIX_WIDTH-1:0] mk2(input int a0, input int a1);
        logic [PIX_WIDTH-1:0] r;
        r = '0;
        r[0 +: DATA_WIDTH] = 8'(a0);
        r[DATA_WIDTH +: DATA_WIDTH] = 8'(a1);
        return r;
    endfunction

    task automatic push(input logic rs, input logic prst, input logic v, input logic [PIX_WIDTH-1:0] din,
                        input logic ev, input logic edone, input logic chk, input logic [PIX_WIDTH-1:0] ed);
        vec_t t;
        t.rs = rs; t.prst = prst; t.v = v; t.en = cur_en; t.len = cur_len; t.din = din;
        t.ev = ev; t.edone = edone; t.chk = chk; t.ed = ed;
        q.push_back(t);
    endtask

    task automatic beat(input int p);
        push(1'b0, 1'b0, 1'b1, mk(p), 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic beat_out(input int p, input int mx, input int mn, input logic done);
        push(1'b0, 1'b0, 1'b1, mk(p), 1'b1, done, 1'b1, mk_exp(mx, mn));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic restart(input int len, input logic en);
        cur_len = LEN_WIDTH'(len);
        cur_en  = en;
        push(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Pixels increase in raster order, so a completed window's max is the current pixel
    // and its min sits one row and one column back (p-5 for width 4).
    task automatic frame4(input int base, input int maxgap);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (r % 2 == 1 && c % 2 == 1) beat_out(base + 4*r + c + 1, base + 4*r + c + 1, base + 4*r + c - 4, c == 3);
                else beat(base + 4*r + c + 1);
                idle(maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
            end
    endtask

    task automatic six_beats();
        for (int p = 1; p <= 5; p++) beat(p);
        beat_out(6, 6, 1, 1'b0);
    endtask

    initial begin
        logic [PIX_WIDTH-1:0] d;
        logic                 v;
        cur_len = LEN_WIDTH'(4);
        cur_en  = 1'b1;
        push(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, '0);
        frame4(0, 0);
        restart(2, 1'b1);
        push(1'b0, 1'b0, 1'b1, mk2(-128, 127), 1'b0, 1'b0, 1'b0, '0);
        push(1'b0, 1'b0, 1'b1, mk2(-1, -128), 1'b0, 1'b0, 1'b0, '0);
        push(1'b0, 1'b0, 1'b1, mk2(-5, 0), 1'b0, 1'b0, 1'b0, '0);
        push(1'b0, 1'b0, 1'b1, mk2(-2, 1), 1'b1, 1'b1, 1'b1, mk2(-1, 127));
        restart(5, 1'b1);
        for (int p = 1; p <= 6; p++) beat(p);
        beat_out(7, 7, 1, 1'b0);
        beat(8);
        beat_out(9, 9, 3, 1'b1);
        beat(10);
        idle(2);
        restart(4, 1'b0);
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < CH_NUM; k++) d[k*DATA_WIDTH +: DATA_WIDTH] = 8'($urandom);
            v = 1'($urandom_range(0, 1));
            push(1'b0, 1'b0, v, d, v, 1'b0, v, d);
        end
        restart(4, 1'b1);
        frame4(0, 3);
        six_beats();
        cur_len = LEN_WIDTH'(4);
        push(1'b0, 1'b1, 1'b1, mk(7), 1'b0, 1'b0, 1'b0, '0);
        frame4(40, 0);
        six_beats();
        push(1'b1, 1'b0, 1'b1, mk(99), 1'b0, 1'b0, 1'b1, '0);
        frame4(20, 0);
        idle(2);

        for (int i = 0; i < q.size(); i++) begin
            rst           = q[i].rs;
            pool_rst      = q[i].prst;
            pool_valid_in = q[i].v;
            pool_en       = q[i].en;
            line_len      = q[i].len;
            pool_data_in  = q[i].din;
            @(posedge clk);
            #1;
            n_chk++;
            if (pool_valid_out !== q[i].ev) begin
                n_fail++;
                $display("FAIL valid[%0d]: got %b want %b", i, pool_valid_out, q[i].ev);
            end
            n_chk++;
            if (pool_row_done !== q[i].edone) begin
                n_fail++;
                $display("FAIL row_done[%0d]: got %b want %b", i, pool_row_done, q[i].edone);
            end
            if (q[i].chk) begin
                n_chk++;
                if (pool_data_out !== q[i].ed) begin
                    n_fail++;
                    $display("FAIL data[%0d]: got %h want %h", i, pool_data_out, q[i].ed);
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_max_pool.md
Name: conv_max_pool

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of the convolution unit.
- Consumes the conv output pixel stream: raster order, 18 channels of 8-bit signed data per beat, valid-only, no backpressure.
- Emits one pooled pixel per 2x2 window, or passes data straight through in bypass mode.
- Feeds the next layer's input path.

Parameters:
- CH_NUM, 18, channels per beat (lanes)
- DATA_WIDTH, 8, bits per lane, two's complement
- LEN_WIDTH, 9, width of line_len
- MAX_LEN, 320, maximum input line length in pixels; line buffer depth is MAX_LEN/2

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- pool_rst  in  1  synchronous frame restart; clears counters; samples line_len and pool_en
- pool_en  in  1  1 = pool, 0 = bypass; sampled only at rst/pool_rst
- line_len  in  LEN_WIDTH  input pixels per row; sampled only at rst/pool_rst
- pool_data_in  in  CH_NUM*DATA_WIDTH  input pixel; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- pool_valid_in  in  1  input beat valid
- pool_data_out  out  CH_NUM*DATA_WIDTH  pooled or bypassed pixel, same lane packing
- pool_valid_out  out  1  output beat valid
- pool_row_done  out  1  pulses with the last pooled output of each output row

Behaviour:
- Reset (rst=1): pool_data_out=0, pool_valid_out=0, pool_row_done=0, col_cnt=0, state=EVEN_ROW, pool_en_q=1. Line length is loaded as follows:
  - len_q=line_len, clamped to MAX_LEN.
  - Line buffer contents are not reset; an even row always writes an entry before the odd row reads it.
- pool_rst: same clearing as rst, except outputs are only forced to valid=0 and row_done=0; len_q and pool_en_q are re-sampled.
  - pool_rst has priority: if pool_rst and pool_valid_in are high in the same cycle, the beat is dropped.
- Bypass (pool_en_q=0): registered pass-through. Next cycle, data_out=data_in and valid_out=valid_in. Counters stay at 0; row_done=0.
- Pool mode, counting: col_cnt advances only on valid beats; gaps of any length hold all state.
  - When col_cnt==len_q-1 it wraps to 0 and toggles the state between EVEN_ROW and ODD_ROW.
- Pool mode, per-lane compare: each of the 18 lanes is compared independently using a signed max.
- Even column c (both states): latch the pixel into prev_q.
  - In ODD_ROW, also issue a synchronous line-buffer read at address c>>1. RAM read data is held until the next read.
- Odd column c, EVEN_ROW: write hmax=max(prev_q, pixel) to buf[c>>1]. No output.
- Odd column c, ODD_ROW: on the next cycle, data_out=max(buf_rdata, hmax) and valid_out=1.
  - Latency is exactly 1 cycle from the completing input beat.
  - row_done=1 in that same cycle if c==2*(len_q>>1)-1.
- Odd len_q: the last column of each row is counted but ignored, with no write and no output.
- len_q<2: no pooled output ever. Counters still wrap on every valid beat and toggle state.
- Odd frame height: the trailing unpaired row produces nothing. It is cleared by the next pool_rst.
- Output throughput is at most 1 per 2 input beats. valid_out is a single-cycle pulse per output; data_out holds its value when valid_out=0.

Decomposition:
- Shared header/package holds CH_NUM, DATA_WIDTH, LEN_WIDTH, MAX_LEN and the state encodings (EVEN_ROW=0, ODD_ROW=1). The conv unit and downstream stages use the same constants.
- One sub-module: pool_line_buf.
  - Simple dual-port RAM, depth MAX_LEN/2, width CH_NUM*DATA_WIDTH.
  - Synchronous read with read-enable; output register held when read-enable is low.
  - Infers block RAM.
- Lane max is a generate loop in the top level, not a separate module.

Test Plan:
- Pool 4x4, len=4, lane0 rows 1-4, 5-8, 9-12, 13-16, continuous valid: outputs 6, 8, 14, 16, each 1 cycle after inputs 6, 8, 14, 16. row_done is asserted with 8 and 16; all other lanes are checked with distinct patterns.
- Signed compare, len=2, lane0 inputs -128, -1 / -5, -2: output 0xFF (-1). Lane1 inputs 127, -128 / 0, 1: output 0x7F.
- Odd width, len=5, rows 1-5 and 6-10: outputs 7 and 9 only; row_done with 9. Pixels 5 and 10 produce nothing; the next row starts at col 0.
- Bypass with pool_en=0 at pool_rst: random beats with random valid gaps reappear unchanged 1 cycle later. row_done stays 0.
- Valid gaps plus pool_rst collision: the 4x4 case with 0-3 idle cycles between beats gives results identical to case 1.
  - pool_rst asserted together with a valid beat mid-frame drops that beat and clears counters.
  - A fresh 4x4 frame then pools correctly.
- rst mid-frame, after 6 beats of a len=4 frame: all outputs read 0 the next cycle. The following full frame pools correctly with no stale buffer influence.
